// File: rtl/raster_output_fifo.sv
// -----------------------------------------------------------------------------
// raster_output_fifo
//
// Decoupling FIFO between the raster stage and the shadow/shading stage.
// Each one-cycle write strobe from the raster unit is captured into a small
// circular buffer. The head entry is presented first-word-fall-through to the
// downstream consumer using a ready/valid handshake. Every entry also carries
// a shadow tag that tells the shading stage whether a shadow ray must be
// traced for it.
//
// Build option (macro): RASTER_OUTPUT_MISS_BYPASS_EN
//   defined   : the shadow tag is (SurfaceType != ST_None), so primary misses
//               leave with out_shadow = 0.
//   undefined : the shadow tag is constantly 1.
//   The queue behaviour and the data path are identical in both builds.
//
// Parameters
//   DEPTH       number of entries (power of two, >= 2)
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   in_valid    one-cycle write strobe (raster 'valid')
//   in_data     entry to store, sampled when in_valid = 1
//   in_full     backpressure to the raster unit (output_fifo_full)
//   out_valid   head entry available
//   out_ready   consumer accepts the head entry this cycle
//   out_data    head entry (don't-care while out_valid = 0)
//   out_shadow  head entry needs a shadow-ray trace (0 while empty)
//   count       current occupancy, 0..DEPTH
//   overflow    sticky flag, set when a write is dropped; cleared by reset
// -----------------------------------------------------------------------------

package raster_output_pkg;

    typedef enum logic [1:0] {
        ST_None       = 2'd0,
        ST_Diffuse    = 2'd1,
        ST_Reflective = 2'd2,
        ST_Emissive   = 2'd3
    } surface_type_t;

    typedef struct packed {
        logic [47:0]   ShadowingRay;
        logic [47:0]   HitPos;
        logic [23:0]   Color;
        logic [15:0]   VI;
        logic [9:0]    x;
        logic [9:0]    y;
        logic [2:0]    BounceLevel;
        surface_type_t SurfaceType;
    } RasterOutputData;

endpackage

module raster_output_fifo
    import raster_output_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  RasterOutputData         in_data,
    output logic                    in_full,
    output logic                    out_valid,
    input  logic                    out_ready,
    output RasterOutputData         out_data,
    output logic                    out_shadow,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             CW         = AW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    // Storage: payload array plus one shadow tag per entry. Neither is
    // reset; out_valid gates every use of the contents.
    RasterOutputData  mem [DEPTH];
    logic [DEPTH-1:0] shadow_mem;

    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    logic             push;
    logic             pop;
    logic             drop;
    logic             in_shadow;

    // Status flags come straight from the registered count, so in_full
    // reacts one cycle after the filling push and one cycle after the
    // first pop from full.
    assign in_full   = (count == FULL_COUNT);
    assign out_valid = (count != '0);

    // A pop frees a slot in the same cycle, so a write arriving while full
    // is still accepted when the consumer drains the head at the same edge.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!in_full || pop);
    assign drop = in_valid && in_full && !pop;

`ifdef RASTER_OUTPUT_MISS_BYPASS_EN
    // Primary misses have nothing to shadow; tag them so shading can skip.
    assign in_shadow = (in_data.SurfaceType != ST_None);
`else
    assign in_shadow = 1'b1;
`endif

    // First-word-fall-through read: no bypass when empty, so a fresh entry
    // appears on the outputs only after the edge that wrote it.
    assign out_data   = mem[rd_ptr];
    assign out_shadow = shadow_mem[rd_ptr] & out_valid;

    // Control state: pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Payload and tag storage. A write in the reset cycle is suppressed so
    // that a strobe coinciding with reset leaves no trace.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr]        <= in_data;
            shadow_mem[wr_ptr] <= in_shadow;
        end
    end

endmodule
